// File: rtl/dmem_pkg.sv
// Shared types and lane constants for the data-memory arbiter and the lane encoder.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;

  typedef enum logic {IDLE, RESP} state_e;

  localparam logic [3:0] LANE_B0 = 4'b0001;
  localparam logic [3:0] LANE_B1 = 4'b0010;
  localparam logic [3:0] LANE_B2 = 4'b0100;
  localparam logic [3:0] LANE_B3 = 4'b1000;
  localparam logic [3:0] LANE_H0 = 4'b0011;
  localparam logic [3:0] LANE_H1 = 4'b1100;
  localparam logic [3:0] LANE_W  = 4'b1111;

  // Bit of the read code that asks the memory to sign-extend the loaded value.
  localparam int unsigned RMEM_SIGNED = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: requests in, grants and responses out.
interface dmem_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [2*NREQ-1:0]  req_size;
  logic [NREQ-1:0]    req_uns;
  logic [32*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [31:0]        rsp_data;
  logic               rsp_err;

  modport master (
    output req, req_we, req_size, req_uns, req_addr, req_wdata, rsp_ready,
    input  gnt, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req, req_we, req_size, req_uns, req_addr, req_wdata, rsp_ready,
    output gnt, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dmem_lane_enc.sv
// Combinational byte-address to word-memory translation: lane codes, word index, error flag.
module dmem_lane_enc
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  size_e       size,
  input  logic        uns,
  input  logic        we,
  input  logic [31:0] addr,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic        err,
  output logic [31:0] word_idx
);

  logic [1:0] o;
  logic [3:0] mask;
  logic       bad_align;
  logic       out_of_range;

  always_comb begin
    o         = addr[1:0];
    mask      = '0;
    bad_align = 1'b0;
    unique case (size)
      SZ_B: begin
        unique case (o)
          2'd0:    mask = LANE_B0;
          2'd1:    mask = LANE_B1;
          2'd2:    mask = LANE_B2;
          default: mask = LANE_B3;
        endcase
      end
      SZ_H: begin
        mask      = o[1] ? LANE_H1 : LANE_H0;
        bad_align = o[0];
      end
      SZ_W: begin
        mask      = LANE_W;
        bad_align = (o != 2'b00);
      end
      default: bad_align = 1'b1;
    endcase

    out_of_range = (addr >> (ADDR_W + 2)) != 32'd0;
    err          = bad_align | out_of_range;

    // Any error suppresses the memory access entirely.
    wmem = '0;
    rmem = '0;
    if (!err) begin
      if (we) begin
        wmem = mask;
      end else begin
        rmem[3:0]         = mask;
        rmem[RMEM_SIGNED] = ~uns & (size != SZ_W);
      end
    end

    word_idx = 32'(addr[ADDR_W+1:2]);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between CPU (0) and debug (1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned NREQ   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus,
  output logic [3:0]     wmem,
  output logic [4:0]     rmem,
  output logic [31:0]    mem_addr,
  output logic [31:0]    store_data,
  input  logic [31:0]    load_data
);

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            win_q, win_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            win;
  logic            grant;
  logic [NREQ-1:0] gnt_c;
  size_e           sel_size;
  logic            sel_we, sel_uns;
  logic [31:0]     sel_addr, sel_wdata;
  logic [3:0]      enc_wmem;
  logic [4:0]      enc_rmem;
  logic            enc_err;
  logic [31:0]     enc_idx;

  // Winner selection and request-field mux.
  always_comb begin
    win = ptr_q;
    if (!bus.req[ptr_q]) win = ~ptr_q;
    grant = (state_q == IDLE) && (|bus.req);
    if (win) begin
      sel_size  = size_e'(bus.req_size[3:2]);
      sel_we    = bus.req_we[1];
      sel_uns   = bus.req_uns[1];
      sel_addr  = bus.req_addr[63:32];
      sel_wdata = bus.req_wdata[63:32];
    end else begin
      sel_size  = size_e'(bus.req_size[1:0]);
      sel_we    = bus.req_we[0];
      sel_uns   = bus.req_uns[0];
      sel_addr  = bus.req_addr[31:0];
      sel_wdata = bus.req_wdata[31:0];
    end
  end

  dmem_lane_enc #(
    .ADDR_W (ADDR_W)
  ) u_lane_enc (
    .size     (sel_size),
    .uns      (sel_uns),
    .we       (sel_we),
    .addr     (sel_addr),
    .wmem     (enc_wmem),
    .rmem     (enc_rmem),
    .err      (enc_err),
    .word_idx (enc_idx)
  );

  // Memory side is only driven during the grant cycle.
  always_comb begin
    gnt_c      = '0;
    wmem       = '0;
    rmem       = '0;
    mem_addr   = '0;
    store_data = '0;
    if (grant) begin
      gnt_c[win] = 1'b1;
      wmem       = enc_wmem;
      rmem       = enc_rmem;
      mem_addr   = enc_idx;
      store_data = sel_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d     = RESP;
          win_d       = win;
          ptr_d       = ~win;
          rsp_valid_d = gnt_c;
          rsp_err_d   = enc_err;
          rsp_data_d  = (enc_err || sel_we) ? 32'd0 : load_data;
        end
      end
      default: begin
        if (bus.rsp_ready[win_q]) begin
          state_d     = IDLE;
          rsp_valid_d = '0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      win_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory and a response scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NREQ(2)) bus ();

  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;

  dmem_arbiter #(
    .ADDR_W (12),
    .NREQ   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .wmem       (wmem),
    .rmem       (rmem),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .load_data  (load_data)
  );

  // Memory model: lanes written from right-aligned data, loads extended per read code.
  logic [31:0] mem [4096];
  logic [31:0] merged, wsh, lw;

  function automatic int low_lane(input logic [3:0] m);
    if (m[0]) return 0;
    if (m[1]) return 1;
    if (m[2]) return 2;
    return 3;
  endfunction

  always_comb begin
    wsh = store_data << (8 * low_lane(wmem));
    merged = mem[mem_addr[11:0]];
    for (int k = 0; k < 4; k++) if (wmem[k]) merged[8*k +: 8] = wsh[8*k +: 8];
  end

  always @(posedge clk) if (wmem != 4'b0) mem[mem_addr[11:0]] <= merged;

  always_comb begin
    lw = mem[mem_addr[11:0]] >> (8 * low_lane(rmem[3:0]));
    case (rmem[3:0])
      4'b1111:                            load_data = lw;
      4'b0011, 4'b1100:                   load_data = rmem[4] ? {{16{lw[15]}}, lw[15:0]}
                                                              : {16'b0, lw[15:0]};
      4'b0001, 4'b0010, 4'b0100, 4'b1000: load_data = rmem[4] ? {{24{lw[7]}}, lw[7:0]}
                                                              : {24'b0, lw[7:0]};
      default:                            load_data = 32'd0;
    endcase
  end

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_vld"}, 32'(bus.rsp_valid), 32'(e.vld));
    check({tag, "_data"}, bus.rsp_data, e.data);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
  endtask

  task automatic set_req(input int p, input logic we, input size_e sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_we[p]            = we;
    bus.req_size[2*p +: 2]   = sz;
    bus.req_uns[p]           = uns;
    bus.req_addr[32*p +: 32] = addr;
    bus.req_wdata[32*p +: 32] = wdata;
    bus.req[p]               = 1'b1;
  endtask

  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) return;
    end
    check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  // One complete transaction; response held `hold` extra cycles before rsp_ready.
  task automatic txn(input string tag, input int p, input logic we, input size_e sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] ew, input logic [4:0] er, input logic [31:0] edata,
                     input logic eerr, input int hold);
    logic [1:0] oh;
    oh = 2'b01 << p;
    @(posedge clk); #1;
    set_req(p, we, sz, uns, addr, wdata);
    sbq.push_back('{vld: oh, data: edata, err: eerr});
    wait_gnt(tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(oh));
    check({tag, "_wmem"}, 32'(wmem), 32'(ew));
    check({tag, "_rmem"}, 32'(rmem), 32'(er));
    if (!eerr) check({tag, "_maddr"}, mem_addr, 32'(addr[13:2]));
    if (we) check({tag, "_sdata"}, store_data, wdata);
    @(posedge clk); #1;
    bus.req[p] = 1'b0;
    @(negedge clk);
    pop_cmp(tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, 32'(bus.rsp_valid), 32'(oh));
      check({tag, "_hold_data"}, bus.rsp_data, edata);
    end
    @(posedge clk); #1;
    bus.rsp_ready[p] = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    check({tag, "_vld_clr"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = '0; bus.req_we = '0; bus.req_size = '0; bus.req_uns = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_vld", 32'(bus.rsp_valid), 32'd0);
    check("rst_data", bus.rsp_data, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    check("rst_wmem", 32'(wmem), 32'd0);
    check("rst_rmem", 32'(rmem), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_sdata", store_data, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_vld", 32'(bus.rsp_valid), 32'd0);
    end

    txn("st_b6", 0, 1'b1, SZ_B, 1'b0, 32'h6, 32'hAB, 4'b0100, 5'b0, 32'd0, 1'b0, 0);
    txn("st_w4", 0, 1'b1, SZ_W, 1'b0, 32'h4, 32'h8001_0000, 4'b1111, 5'b0, 32'd0, 1'b0, 0);
    txn("ld_hs6", 0, 1'b0, SZ_H, 1'b0, 32'h6, 32'd0, 4'b0, 5'b11100, 32'hFFFF_8001, 1'b0, 3);
    txn("ld_bu7", 0, 1'b0, SZ_B, 1'b1, 32'h7, 32'd0, 4'b0, 5'b01000, 32'h80, 1'b0, 0);
    txn("ld_hu6", 1, 1'b0, SZ_H, 1'b1, 32'h6, 32'd0, 4'b0, 5'b01100, 32'h8001, 1'b0, 0);
    txn("err_w2", 1, 1'b0, SZ_W, 1'b0, 32'h2, 32'd0, 4'b0, 5'b0, 32'd0, 1'b1, 0);
    txn("err_oor", 1, 1'b0, SZ_W, 1'b0, 32'h0001_0000, 32'd0, 4'b0, 5'b0, 32'd0, 1'b1, 0);
    txn("err_sz", 0, 1'b1, SZ_BAD, 1'b0, 32'h4, 32'h55, 4'b0, 5'b0, 32'd0, 1'b1, 0);
    txn("st_h4", 1, 1'b1, SZ_H, 1'b0, 32'h4, 32'h5678_1234, 4'b0011, 5'b0, 32'd0, 1'b0, 0);
    txn("ld_w4", 0, 1'b0, SZ_W, 1'b0, 32'h4, 32'd0, 4'b0, 5'b01111, 32'h8001_1234, 1'b0, 0);

    // Stalled response with port 1 waiting; stray ready on the non-winner is ignored.
    @(posedge clk); #1;
    set_req(0, 1'b0, SZ_H, 1'b0, 32'h6, 32'd0);
    sbq.push_back('{vld: 2'b01, data: 32'hFFFF_8001, err: 1'b0});
    wait_gnt("stall");
    check("stall_gnt0", 32'(bus.gnt), 32'h1);
    @(posedge clk); #1;
    bus.req[0] = 1'b0;
    set_req(1, 1'b0, SZ_W, 1'b0, 32'h4, 32'd0);
    sbq.push_back('{vld: 2'b10, data: 32'h8001_1234, err: 1'b0});
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    pop_cmp("stall_rsp0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_nognt", 32'(bus.gnt), 32'd0);
      check("stall_vld", 32'(bus.rsp_valid), 32'h1);
      check("stall_data", bus.rsp_data, 32'hFFFF_8001);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    check("stall_rdy_nognt", 32'(bus.gnt), 32'd0);
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    check("stall_gnt1", 32'(bus.gnt), 32'h2);
    check("stall_rmem1", 32'(rmem), 32'h0F);
    @(posedge clk); #1;
    bus.req[1] = 1'b0;
    @(negedge clk);
    pop_cmp("stall_rsp1");
    @(posedge clk); #1;
    bus.rsp_ready = 2'b10;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;

    // Async reset, then both ports requesting continuously with ready tied high.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst2_vld", 32'(bus.rsp_valid), 32'd0);
    check("rst2_gnt", 32'(bus.gnt), 32'd0);
    set_req(0, 1'b0, SZ_W, 1'b0, 32'h4, 32'd0);
    set_req(1, 1'b0, SZ_B, 1'b1, 32'h7, 32'd0);
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back('{vld: 2'b01, data: 32'h8001_1234, err: 1'b0});
      sbq.push_back('{vld: 2'b10, data: 32'h80, err: 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      logic [1:0] eg, ev;
      eg = (c % 2 != 0) ? 2'b00 : ((c % 4 == 0) ? 2'b01 : 2'b10);
      ev = (c % 2 == 0) ? 2'b00 : ((c % 4 == 1) ? 2'b01 : 2'b10);
      check("rr_gnt", 32'(bus.gnt), 32'(eg));
      check("rr_vld", 32'(bus.rsp_valid), 32'(ev));
      if (bus.rsp_valid != 2'b00) pop_cmp("rr_rsp");
      @(negedge clk);
      #1;
    end
    bus.req = 2'b00;
    bus.rsp_ready = 2'b00;
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
